imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder for the single-cycle CPU's fetch interface: the CPU drives the byte-address PC, and this block returns the 32-bit instruction word.
- Models a multi-cycle memory with a BUSYWAIT handshake so the CPU can stall its PC and register writes while a fetch is in flight.
- Holds a word array that is preloaded through a sideband load port, used by testbench or boot loader.
- Sits between PC_OUT and INSTRUCTION at top level.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; must be a power of 2, ≥4.
- LATENCY, 4, clock edges from request capture to data return; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- READ  input  1  fetch request from CPU.
- ADDRESS  input  32  byte address (PC) of requested instruction.
- INSTRUCTION  output  32  fetched instruction word, registered.
- BUSYWAIT  output  1  high while a fetch is in flight; CPU must stall.
- ADDR_ERR  output  1  registered flag for the last completed fetch: misaligned or out of range.
- LOAD_EN  input  1  write enable for the preload port.
- LOAD_ADDR  input  32  byte address for preload; bits [1:0] ignored.
- LOAD_DATA  input  32  word to store.

Behaviour:
- Reset (RESET_N low, async): state IDLE, INSTRUCTION=0x00000000, BUSYWAIT=0, ADDR_ERR=0, latency counter=0, captured address=0. Array contents are NOT cleared.
- States: IDLE, FETCH, DONE.
- IDLE: at an edge with READ=1, capture ADDRESS, load counter=LATENCY-1, go FETCH, BUSYWAIT=1 after that edge.
- FETCH: each edge, decrement counter while nonzero.
  - At the edge where counter==0, load INSTRUCTION, update ADDR_ERR, set BUSYWAIT=0, go DONE.
  - Net: capture edge E0 → data visible after edge E0+LATENCY.
- DONE: INSTRUCTION held.
  - READ=1 and ADDRESS==captured: stay DONE, no refetch.
  - READ=1 and ADDRESS differs: capture a new fetch as in IDLE.
  - READ=0: go IDLE.
- ADDRESS and READ changes during FETCH are ignored; the in-flight fetch completes with the captured address.
- Word index = captured ADDRESS[31:2].
  - Index ≥ DEPTH_WORDS: INSTRUCTION=0x00000000, ADDR_ERR=1.
  - ADDRESS[1:0]≠0: return the word at the aligned index, ADDR_ERR=1.
- Load port:
  - At an edge with LOAD_EN=1 and in-range index, write the array.
  - Out-of-range loads are dropped silently.
  - Loads are permitted in any state.
  - A fetch completing on the same edge as a load to the same word returns the OLD word (read-before-write).
- RESET_N asserted mid-FETCH aborts the fetch: BUSYWAIT drops immediately (async), and no data is returned.

Optional Feature:
- Macro IMEM_PREFETCH_EN.
- Defined:
  - On every fetch completion at word index W, also latch the word at W+1 into a prefetch buffer and mark it valid. W+1 wraps modulo DEPTH_WORDS, and the buffer is marked invalid if W+1 is out of range.
  - A new request whose aligned index equals the buffer index and whose buffer is valid completes with latency 1: BUSYWAIT high for exactly one cycle, and that completion in turn prefetches the next word.
  - A LOAD_EN write to the buffered index, or reset, invalidates the buffer.
  - Misaligned requests never hit the buffer.
- Not defined: no buffer; every fetch takes LATENCY edges.

Test Plan:
- Reset, preload word0=0x00020100, word1=0x01030202, READ=1 ADDRESS=0 (LATENCY=4) → BUSYWAIT high 4 cycles, then INSTRUCTION=0x00020100, ADDR_ERR=0; held in DONE with no second BUSYWAIT pulse.
- After the above, ADDRESS=4 while in DONE → new fetch, 4-cycle BUSYWAIT, INSTRUCTION=0x01030202. With IMEM_PREFETCH_EN: 1-cycle BUSYWAIT, same data.
- READ ADDRESS=0x00000402 (DEPTH_WORDS=256, index 256) → INSTRUCTION=0x00000000, ADDR_ERR=1. READ ADDRESS=0x00000006 → word1 returned, ADDR_ERR=1.
- Change ADDRESS from 0 to 8 at cycle 2 of a fetch → completion returns word0 (captured address). DONE then sees the mismatch and fetches word2.
- LOAD_EN word0=0xDEADBEEF on the same edge as a word0 fetch completes → INSTRUCTION shows the old value. A refetch of word0 returns 0xDEADBEEF. With IMEM_PREFETCH_EN, a load to the buffered word forces the full LATENCY on the next hit.
- Drop RESET_N mid-FETCH → BUSYWAIT=0 and INSTRUCTION=0 immediately. After release, state is IDLE and a new READ gets the full LATENCY with correct data.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch and preload bus between the CPU (master) and the instruction memory responder (slave).
interface imem_responder_if;
  logic        read;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        busywait;
  logic        addr_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (
    output read, address, load_en, load_addr, load_data,
    input  instruction, busywait, addr_err
  );

  modport slave (
    input  read, address, load_en, load_addr, load_data,
    output instruction, busywait, addr_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: multi-cycle fetch with a BUSYWAIT handshake and a
// sideband preload port. Optional next-word prefetch buffer enabled by the macro
// IMEM_PREFETCH_EN (undefined by default: every fetch takes LATENCY edges).
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input logic             clk,
  input logic             reset_n,
  imem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    count;
  logic [31:0]   cap_addr;
  logic [31:0]   instr_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          start_req;
  logic          finish;
  logic          cap_in_range;
  logic          load_in_range;
  logic [AW-1:0] cap_idx;
  logic [AW-1:0] load_idx;
  logic [31:0]   rd_word;
  logic          pf_hit_req;
  logic          unused_load_bits;

  assign cap_idx          = cap_addr[AW+1:2];
  assign cap_in_range     = (cap_addr[31:AW+2] == '0);
  assign load_idx         = bus.load_addr[AW+1:2];
  assign load_in_range    = (bus.load_addr[31:AW+2] == '0);
  assign finish           = (state == FETCH) && (count == 4'd0);
  assign unused_load_bits = ^bus.load_addr[1:0];

`ifdef IMEM_PREFETCH_EN
  logic          pf_valid;
  logic [AW-1:0] pf_idx;
  logic [31:0]   pf_data;
  logic          hit_q;
  logic [AW-1:0] nxt_idx;

  // A request hits only when aligned, in range, matching a valid buffer, and not racing a load to that word
  assign pf_hit_req = pf_valid && (bus.address[1:0] == 2'b00) &&
                      (bus.address[31:AW+2] == '0) && (bus.address[AW+1:2] == pf_idx) &&
                      !(bus.load_en && load_in_range && (load_idx == pf_idx));
  assign nxt_idx    = cap_idx + AW'(1);

  // Prefetch buffer: latch the following word on each completion, drop it when that word is reloaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_valid <= 1'b0;
      pf_idx   <= '0;
      pf_data  <= 32'h0;
      hit_q    <= 1'b0;
    end else begin
      if (start_req) hit_q <= pf_hit_req;
      if (finish && cap_in_range) begin
        pf_idx   <= nxt_idx;
        pf_data  <= mem[nxt_idx];
        pf_valid <= !(bus.load_en && load_in_range && (load_idx == nxt_idx));
      end else if (finish) begin
        pf_valid <= 1'b0;
      end else if (bus.load_en && load_in_range && (load_idx == pf_idx)) begin
        pf_valid <= 1'b0;
      end
    end
  end
`else
  assign pf_hit_req = 1'b0;
`endif

  // A new fetch starts from IDLE on any read, or from DONE when the PC moved away
  always_comb begin
    start_req = 1'b0;
    if (bus.read) begin
      if (state == IDLE) start_req = 1'b1;
      else if ((state == DONE) && (bus.address != cap_addr)) start_req = 1'b1;
    end
  end

  // Word returned at completion; the array read sees the pre-edge contents (read-before-write)
  always_comb begin
    rd_word = 32'h0;
    if (cap_in_range) rd_word = mem[cap_idx];
`ifdef IMEM_PREFETCH_EN
    if (hit_q) rd_word = pf_data;
`endif
  end

  // State register; reset aborts any in-flight fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.read) state_next = FETCH;
      FETCH:   if (count == 4'd0) state_next = DONE;
      DONE: begin
        if (!bus.read)                       state_next = IDLE;
        else if (bus.address != cap_addr)    state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // BUSYWAIT is high exactly while a fetch is in flight, so reset drops it at once
  always_comb begin
    bus.busywait = (state == FETCH);
  end

  // Capture address, run the latency counter, and register the completed result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 4'd0;
      cap_addr <= 32'h0;
      instr_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (start_req) begin
      cap_addr <= bus.address;
      count    <= pf_hit_req ? 4'd0 : 4'(LATENCY - 1);
    end else if (state == FETCH) begin
      if (count != 4'd0) begin
        count <= count - 4'd1;
      end else begin
        instr_q <= rd_word;
        err_q   <= !cap_in_range || (cap_addr[1:0] != 2'b00);
      end
    end
  end

  // Preload port: in-range writes land in the array, out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (bus.load_en && load_in_range) mem[load_idx] <= bus.load_data;
  end

  assign bus.instruction = instr_q;
  assign bus.addr_err    = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: randomized fetches and loads checked against a
// word-level reference model (array contents plus an abstract prefetch-buffer record).
module tb_imem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [31:0] model_mem [DEPTH];
  int          pf_idx_m;
  bit          pf_valid_m;
  logic [31:0] cur_cap;

  imem_responder_if bus();

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside a bounded wait
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: word at an address, or zero beyond the array
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int idx;
    if ((a >> 2) >= DEPTH) return 32'h0;
    idx = int'(a >> 2);
    return model_mem[idx];
  endfunction

  // Reference: error when out of range or not word aligned
  function automatic logic exp_err(input logic [31:0] a);
    return ((a >> 2) >= DEPTH) || (a[1:0] != 2'b00);
  endfunction

  // Reference: one cycle on a buffered aligned word, otherwise the full latency
  function automatic int exp_latency(input logic [31:0] a);
`ifdef IMEM_PREFETCH_EN
    if (pf_valid_m && (a[1:0] == 2'b00) && ((a >> 2) == pf_idx_m)) return 1;
`endif
    return LATENCY;
  endfunction

  // Reference: after finishing word W the following word (mod depth) becomes buffered
  task automatic model_complete(input logic [31:0] a);
    if ((a >> 2) < DEPTH) begin
      pf_idx_m   = (int'(a >> 2) + 1) % DEPTH;
      pf_valid_m = 1'b1;
    end else begin
      pf_valid_m = 1'b0;
    end
  endtask

  // One-cycle write through the preload port, mirrored in the model
  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
    if ((a >> 2) < DEPTH) begin
      model_mem[int'(a >> 2)] = d;
      if (pf_valid_m && ((a >> 2) == pf_idx_m)) pf_valid_m = 1'b0;
    end
  endtask

  // Count how many falling edges see BUSYWAIT high after the request edge
  task automatic measure(output int busy);
    busy = 0;
    @(negedge clk);
    while (bus.busywait === 1'b1 && busy < 40) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    bus.read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.read      = 1'b0;
    bus.address   = 32'h0;
    bus.load_en   = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;
    pf_valid_m    = 1'b0;
    cur_cap       = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busywait !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busywait: got %b expected 0", bus.busywait);
    end
    checks++;
    if (bus.instruction !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_instruction: got %h expected 00000000", bus.instruction);
    end
    checks++;
    if (bus.addr_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_addr_err: got %b expected 0", bus.addr_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) load_word(32'(i) << 2, $urandom());
  endtask

  task automatic test_basic_fetch();
    logic [31:0] addrs [2];
    int busy, lat;
    logic [31:0] w;
    logic e;
    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    load_word(32'h0, 32'h00020100);
    load_word(32'h4, 32'h01030202);
    for (int k = 0; k < 2; k++) begin
      lat = exp_latency(addrs[k]);
      w   = exp_word(addrs[k]);
      e   = exp_err(addrs[k]);
      bus.read    = 1'b1;
      bus.address = addrs[k];
      cur_cap     = addrs[k];
      measure(busy);
      model_complete(addrs[k]);
      checks++;
      if (busy != lat) begin
        errors++; $display("[TB] FAIL basic_latency[%0d]: got %0d expected %0d", k, busy, lat);
      end
      checks++;
      if (bus.instruction !== w) begin
        errors++; $display("[TB] FAIL basic_data[%0d]: got %h expected %h", k, bus.instruction, w);
      end
      checks++;
      if (bus.addr_err !== e) begin
        errors++; $display("[TB] FAIL basic_err[%0d]: got %b expected %b", k, bus.addr_err, e);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (bus.busywait !== 1'b0 || bus.instruction !== w) begin
          errors++;
          $display("[TB] FAIL basic_hold[%0d]: got busywait %b data %h expected 0 %h",
                   k, bus.busywait, bus.instruction, w);
        end
      end
    end
  endtask

  task automatic test_addr_errors();
    logic [31:0] addrs [2];
    int busy, lat;
    logic [31:0] w;
    logic e;
    addrs[0] = 32'h00000402;
    addrs[1] = 32'h00000006;
    for (int k = 0; k < 2; k++) begin
      lat = exp_latency(addrs[k]);
      w   = exp_word(addrs[k]);
      e   = exp_err(addrs[k]);
      bus.address = addrs[k];
      cur_cap     = addrs[k];
      measure(busy);
      model_complete(addrs[k]);
      checks++;
      if (busy != lat) begin
        errors++; $display("[TB] FAIL err_latency[%0d]: got %0d expected %0d", k, busy, lat);
      end
      checks++;
      if (bus.instruction !== w || bus.addr_err !== e) begin
        errors++;
        $display("[TB] FAIL err_result[%0d]: got %h/%b expected %h/%b",
                 k, bus.instruction, bus.addr_err, w, e);
      end
    end
  endtask

  task automatic test_addr_change();
    int busy, lat;
    logic [31:0] w;
    lat = exp_latency(32'h0);
    w   = exp_word(32'h0);
    bus.address = 32'h0;
    busy = 0;
    @(negedge clk);
    while (bus.busywait === 1'b1 && busy < 40) begin
      busy++;
      if (busy == 2) bus.address = 32'h8;
      @(negedge clk);
    end
    model_complete(32'h0);
    checks++;
    if (busy != lat || bus.instruction !== w || bus.addr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL change_captured: got lat %0d data %h err %b expected %0d %h 0",
               busy, bus.instruction, bus.addr_err, lat, w);
    end
    lat = exp_latency(32'h8);
    w   = exp_word(32'h8);
    cur_cap = 32'h8;
    measure(busy);
    model_complete(32'h8);
    checks++;
    if (busy != lat || bus.instruction !== w) begin
      errors++;
      $display("[TB] FAIL change_refetch: got lat %0d data %h expected %0d %h",
               busy, bus.instruction, lat, w);
    end
  endtask

  task automatic test_load_collision();
    int busy, lat;
    logic [31:0] w;
    lat = exp_latency(32'h0);
    w   = exp_word(32'h0);
    bus.address = 32'h0;
    cur_cap     = 32'h0;
    busy = 0;
    @(negedge clk);
    while (bus.busywait === 1'b1 && busy < 40) begin
      busy++;
      if (busy == lat) begin
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h0;
        bus.load_data = 32'hDEADBEEF;
      end
      @(negedge clk);
      bus.load_en = 1'b0;
    end
    model_complete(32'h0);
    model_mem[0] = 32'hDEADBEEF;
    if (pf_valid_m && pf_idx_m == 0) pf_valid_m = 1'b0;
    checks++;
    if (busy != lat || bus.instruction !== w) begin
      errors++;
      $display("[TB] FAIL collision_old: got lat %0d data %h expected %0d %h",
               busy, bus.instruction, lat, w);
    end
    go_idle();
    lat = exp_latency(32'h0);
    bus.read = 1'b1;
    measure(busy);
    model_complete(32'h0);
    checks++;
    if (busy != lat || bus.instruction !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL collision_new: got lat %0d data %h expected %0d deadbeef",
               busy, bus.instruction, lat);
    end
    load_word(32'h4, 32'h13572468);
    lat = exp_latency(32'h4);
    bus.address = 32'h4;
    cur_cap     = 32'h4;
    measure(busy);
    model_complete(32'h4);
    checks++;
    if (busy != LATENCY || busy != lat || bus.instruction !== 32'h13572468) begin
      errors++;
      $display("[TB] FAIL load_invalidate: got lat %0d data %h expected %0d 13572468",
               busy, bus.instruction, LATENCY);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int busy, lat;
    logic [31:0] a;
    logic [31:0] w;
    bus.address = 32'h00000010;
    repeat (3) @(negedge clk);
    reset_n  = 1'b0;
    bus.read = 1'b0;
    #1;
    pf_valid_m = 1'b0;
    checks++;
    if (bus.busywait !== 1'b0 || bus.instruction !== 32'h0 || bus.addr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort: got busywait %b data %h err %b expected 0 00000000 0",
               bus.busywait, bus.instruction, bus.addr_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.busywait !== 1'b0) begin
        errors++; $display("[TB] FAIL post_reset_idle: got busywait %b expected 0", bus.busywait);
      end
    end
    a   = 32'($urandom_range(0, DEPTH - 1)) << 2;
    lat = exp_latency(a);
    w   = exp_word(a);
    bus.read    = 1'b1;
    bus.address = a;
    cur_cap     = a;
    measure(busy);
    model_complete(a);
    checks++;
    if (busy != LATENCY || busy != lat || bus.instruction !== w || bus.addr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_fetch: got lat %0d data %h err %b expected %0d %h 0",
               busy, bus.instruction, bus.addr_err, LATENCY, w);
    end
  endtask

  task automatic test_random();
    int busy, lat, r, li;
    logic [31:0] a;
    logic [31:0] w;
    logic e;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      end else if (r < 7) begin
        li = ((cur_cap >> 2) < DEPTH) ? int'(cur_cap >> 2) : 0;
        a  = 32'((li + 1) % DEPTH) << 2;
      end else if (r == 7) begin
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      end else if (r == 8) begin
        a = $urandom();
        if (a < 32'(DEPTH * 4)) a = a | 32'h00010000;
      end else begin
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        load_word(a, $urandom());
      end
      if ($urandom_range(0, 3) == 0) load_word($urandom(), $urandom());
      if (a == cur_cap || $urandom_range(0, 4) == 0) go_idle();
      lat = exp_latency(a);
      w   = exp_word(a);
      e   = exp_err(a);
      bus.read    = 1'b1;
      bus.address = a;
      cur_cap     = a;
      measure(busy);
      model_complete(a);
      checks++;
      if (busy != lat || bus.instruction !== w || bus.addr_err !== e) begin
        errors++;
        $display("[TB] FAIL random[%0d] addr %h: got lat %0d data %h err %b expected %0d %h %b",
                 i, a, busy, bus.instruction, bus.addr_err, lat, w, e);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_fetch();
    test_addr_errors();
    test_addr_change();
    test_load_collision();
    test_reset_mid_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
